// File: rtl/gaussian_blur_arbiter.sv
// Round-robin owner-per-job arbiter for one Gaussian_Blur engine; 0-cycle pass-through, 1-cycle grant latency.
// Backpressure is forwarded from the engine to the owner only; define GB_ARB_TIMEOUT_EN for the stall watchdog.
module gaussian_blur_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int JOB_PIXELS  = 9,
  parameter int JOB_RESULTS = 1,
  parameter int TIMEOUT     = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         req_rgb_vld,
  input  logic [NUM_REQ*25-1:0]      req_rgb_data,
  output logic [NUM_REQ-1:0]         req_rgb_busy,
  output logic [NUM_REQ-1:0]         req_result_vld,
  output logic [31:0]                req_result_data,
  input  logic [NUM_REQ-1:0]         req_result_busy,
  output logic                       eng_rgb_vld,
  output logic [24:0]                eng_rgb_data,
  input  logic                       eng_rgb_busy,
  input  logic                       eng_result_vld,
  input  logic [31:0]                eng_result_data,
  output logic                       eng_result_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
`ifdef GB_ARB_TIMEOUT_EN
  ,
  output logic                       err_timeout
`endif
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int PW = $clog2(JOB_PIXELS + 1);
  localparam int RW = $clog2(JOB_RESULTS + 1);

  if (NUM_REQ < 2 || NUM_REQ > 4 || JOB_PIXELS < 1 || JOB_RESULTS < 1 || TIMEOUT < 1) begin : g_cfg_check
    $error("gaussian_blur_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t        state_q;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] last_q;
  logic [PW-1:0] pix_q;
  logic [PW-1:0] pix_d;
  logic [RW-1:0] res_q;
  logic [RW-1:0] res_d;
  logic          win_vld;
  logic [GW-1:0] win_id;
  logic          in_xfer;
  logic          res_xfer;
  logic          pix_last;
  logic          res_full;
  logic          res_last;

  always_comb begin
    req_rgb_busy    = '1;
    req_result_vld  = '0;
    req_result_data = '0;
    eng_rgb_vld     = 1'b0;
    eng_rgb_data    = '0;
    eng_result_busy = 1'b1;
    if (state_q == FEED) begin
      eng_rgb_vld           = req_rgb_vld[grant_q];
      eng_rgb_data          = req_rgb_data[int'(grant_q)*25 +: 25];
      req_rgb_busy[grant_q] = eng_rgb_busy;
    end
    // Results are routed in FEED as well, so early results reach the owner.
    if (state_q != IDLE) begin
      req_result_vld[grant_q] = eng_result_vld;
      req_result_data         = eng_result_data;
      eng_result_busy         = req_result_busy[grant_q];
    end
  end

  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!win_vld && req_rgb_vld[(int'(last_q) + i) % NUM_REQ]) begin
        win_vld = 1'b1;
        win_id  = GW'((int'(last_q) + i) % NUM_REQ);
      end
    end
  end

  assign in_xfer  = eng_rgb_vld && !eng_rgb_busy;
  assign res_xfer = eng_result_vld && !eng_result_busy;
  assign pix_d    = pix_q + 1'b1;
  assign res_d    = res_q + 1'b1;
  assign pix_last = in_xfer && (pix_q == PW'(JOB_PIXELS - 1));
  assign res_full = (res_q == RW'(JOB_RESULTS));
  assign res_last = res_xfer && (res_q == RW'(JOB_RESULTS - 1));
  assign grant_id = grant_q;

`ifdef GB_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q;
  logic          err_q;
  assign err_timeout = err_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      pix_q   <= '0;
      res_q   <= '0;
`ifdef GB_ARB_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            grant_q <= win_id;
            last_q  <= win_id;
            state_q <= FEED;
          end
        end
        FEED: begin
          if (in_xfer) pix_q <= pix_d;
          if (res_xfer && !res_full) res_q <= res_d;
          if (pix_last) begin
            if (res_full) begin
              state_q <= IDLE;
              grant_q <= '0;
              pix_q   <= '0;
              res_q   <= '0;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (res_full || res_last) begin
            state_q <= IDLE;
            grant_q <= '0;
            pix_q   <= '0;
            res_q   <= '0;
          end else if (res_xfer) begin
            res_q <= res_d;
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef GB_ARB_TIMEOUT_EN
      // last_q already holds the stalled owner, so the next search starts past it.
      if (state_q == IDLE || in_xfer || res_xfer) begin
        wd_q <= '0;
      end else if (wd_q == WW'(TIMEOUT - 1)) begin
        wd_q    <= '0;
        err_q   <= 1'b1;
        state_q <= IDLE;
        grant_q <= '0;
        pix_q   <= '0;
        res_q   <= '0;
      end else begin
        wd_q <= wd_q + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_gaussian_blur_arbiter.sv
// Directed bench for gaussian_blur_arbiter with NUM_REQ=2, JOB_PIXELS=9, JOB_RESULTS=1, TIMEOUT=16.
module tb_gaussian_blur_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [1:0]  req_rgb_vld;
  logic [49:0] req_rgb_data;
  logic [1:0]  req_rgb_busy;
  logic [1:0]  req_result_vld;
  logic [31:0] req_result_data;
  logic [1:0]  req_result_busy;
  logic        eng_rgb_vld;
  logic [24:0] eng_rgb_data;
  logic        eng_rgb_busy;
  logic        eng_result_vld;
  logic [31:0] eng_result_data;
  logic        eng_result_busy;
  logic        grant_id;
`ifdef GB_ARB_TIMEOUT_EN
  logic        err_timeout;
`endif

  int n_chk  = 0;
  int n_err  = 0;
  int job_no = 0;

  always #5 i_clk = ~i_clk;

  gaussian_blur_arbiter #(
    .NUM_REQ(2), .JOB_PIXELS(9), .JOB_RESULTS(1), .TIMEOUT(16)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .req_rgb_vld(req_rgb_vld), .req_rgb_data(req_rgb_data), .req_rgb_busy(req_rgb_busy),
    .req_result_vld(req_result_vld), .req_result_data(req_result_data),
    .req_result_busy(req_result_busy),
    .eng_rgb_vld(eng_rgb_vld), .eng_rgb_data(eng_rgb_data), .eng_rgb_busy(eng_rgb_busy),
    .eng_result_vld(eng_result_vld), .eng_result_data(eng_result_data),
    .eng_result_busy(eng_result_busy),
    .grant_id(grant_id)
`ifdef GB_ARB_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_rgb_busy"}, 32'(req_rgb_busy), 32'h3);
    chk({pfx, "_res_vld"}, 32'(req_result_vld), 32'h0);
    chk({pfx, "_res_dat"}, req_result_data, 32'h0);
    chk({pfx, "_eng_vld"}, 32'(eng_rgb_vld), 32'h0);
    chk({pfx, "_eng_dat"}, 32'(eng_rgb_data), 32'h0);
    chk({pfx, "_eng_rbusy"}, 32'(eng_result_busy), 32'h1);
    chk({pfx, "_grant"}, 32'(grant_id), 32'h0);
  endtask

  // Starts in an IDLE cycle; mode 0 plain, 1 backpressure, 2 early result after pixel 7.
  task automatic do_job(input int k, input int mode, input logic [31:0] res, input bit hold);
    int          sent;
    int          cyc;
    bit          tog;
    logic [24:0] base;
    base = 25'(k * 32'h10000 + job_no * 32'h100);
    job_no++;
    req_rgb_vld[k] = 1'b1;
    req_rgb_data[k*25 +: 25] = base + 25'd1;
    tick();
    chk("grant", 32'(grant_id), 32'(k));
    sent = 0;
    cyc  = 0;
    tog  = 1'b0;
    while (sent < 9 && cyc < 60) begin
      req_rgb_data[k*25 +: 25] = base + 25'(sent + 1);
      eng_rgb_busy = (mode == 1) ? tog : 1'b0;
      tog = ~tog;
      if (mode == 2 && sent == 7) begin
        eng_result_vld  = 1'b1;
        eng_result_data = res;
      end else begin
        eng_result_vld = 1'b0;
      end
      #1;
      chk("loser_busy", 32'(req_rgb_busy[1-k]), 32'h1);
      chk("own_busy", 32'(req_rgb_busy[k]), 32'(eng_rgb_busy));
      if (mode == 2 && sent == 7) begin
        chk("early_vld", 32'(req_result_vld), 32'(1 << k));
        chk("early_dat", req_result_data, res);
      end
      if (!eng_rgb_busy) begin
        chk("pix_vld", 32'(eng_rgb_vld), 32'h1);
        chk("pix_dat", 32'(eng_rgb_data), 32'(base + 25'(sent + 1)));
        sent++;
      end
      tick();
      cyc++;
    end
    chk("pix_count", 32'(sent), 32'd9);
    eng_rgb_busy   = 1'b0;
    eng_result_vld = 1'b0;
    if (mode == 2) begin
      req_rgb_vld[k] = 1'b0;
      #1;
      chk("direct_idle", 32'(eng_result_busy), 32'h1);
      chk("direct_idle_vld", 32'(eng_rgb_vld), 32'h0);
    end else begin
      #1;
      chk("drain_block", 32'(eng_rgb_vld), 32'h0);
      chk("drain_busy", 32'(req_rgb_busy), 32'h3);
      chk("drain_rbusy", 32'(eng_result_busy), 32'h0);
      tick();
      req_rgb_vld[k]  = 1'b0;
      eng_result_vld  = 1'b1;
      eng_result_data = res;
      if (mode == 1) begin
        req_result_busy[k] = 1'b1;
        for (int i = 0; i < 5; i++) begin
          #1;
          chk("res_hold", 32'(req_result_vld), 32'(1 << k));
          chk("res_stall", 32'(eng_result_busy), 32'h1);
          tick();
        end
        req_result_busy[k] = 1'b0;
      end
      #1;
      chk("res_vld", 32'(req_result_vld), 32'(1 << k));
      chk("res_dat", req_result_data, res);
      chk("res_acc", 32'(eng_result_busy), 32'h0);
      tick();
      eng_result_vld = 1'b0;
      #1;
      chk("idle_after", 32'(eng_result_busy), 32'h1);
      chk("idle_res_vld", 32'(req_result_vld), 32'h0);
    end
    req_rgb_vld[k] = hold;
  endtask

  initial begin
    req_rgb_vld     = '0;
    req_rgb_data    = '0;
    req_result_busy = '0;
    eng_rgb_busy    = 1'b0;
    eng_result_vld  = 1'b0;
    eng_result_data = 32'h1234_5678;
    #3 i_rst = 1'b0;
    #4;
    chk_reset_outputs("rst");
    tick();
    i_rst = 1'b1;

    // Single requester, pixels 1..9, result DEADBEEF.
    do_job(0, 0, 32'hDEAD_BEEF, 1'b0);

    // Contention straight after reset: 0,1,0,1.
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    req_rgb_vld = 2'b11;
    do_job(0, 0, 32'hC0DE_0001, 1'b1);
    do_job(1, 0, 32'hC0DE_0002, 1'b1);
    do_job(0, 0, 32'hC0DE_0003, 1'b1);
    do_job(1, 0, 32'hC0DE_0004, 1'b0);
    req_rgb_vld = '0;

    // Backpressure on both engine streams.
    do_job(0, 1, 32'hCAFE_0001, 1'b0);

    // Early result, direct FEED to IDLE.
    do_job(1, 2, 32'hBEEF_0002, 1'b0);

    // Reset in the middle of a job.
    req_rgb_vld = 2'b01;
    req_rgb_data[24:0] = 25'd1;
    tick();
    for (int i = 0; i < 4; i++) begin
      req_rgb_data[24:0] = 25'(i + 1);
      tick();
    end
    eng_result_data = 32'hAAAA_5555;
    i_rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick();
    i_rst = 1'b1;
    req_rgb_vld = '0;
    do_job(1, 0, 32'h0BAD_F00D, 1'b0);

`ifdef GB_ARB_TIMEOUT_EN
    // Owner 0 stalls after 3 pixels while requester 1 waits.
    req_rgb_vld = 2'b11;
    req_rgb_data = {25'h1_0000, 25'd1};
    tick();
    chk("wd_grant", 32'(grant_id), 32'h0);
    for (int i = 0; i < 3; i++) begin
      req_rgb_data[24:0] = 25'(i + 1);
      tick();
    end
    req_rgb_vld[0] = 1'b0;
    #1;
    chk("wd_err_early", 32'(err_timeout), 32'h0);
    repeat (15) tick();
    chk("wd_err_15", 32'(err_timeout), 32'h0);
    chk("wd_still_owner", 32'(req_rgb_busy), 32'h2);
    tick();
    chk("wd_err_16", 32'(err_timeout), 32'h1);
    chk("wd_idle_busy", 32'(req_rgb_busy), 32'h3);
    tick();
    chk("wd_regrant", 32'(grant_id), 32'h1);
    chk("wd_err_sticky", 32'(err_timeout), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
